// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared types and constants for the multi-polynomial PRBS generator.
//   prbs_mode_e   : supported polynomials (PRBS7 .. PRBS31)
//   prbs_fsm_e    : generator control states (SEED, RUN)
//   *_LEN / *_TAP : Fibonacci LFSR length L and inner tap T per polynomial,
//                   giving the recurrence b[n] = b[n-L] ^ b[n-T]
//   MAX_LEN       : widest supported polynomial, sizes the state register
//   decode_mode() : maps the raw 3-bit mode input onto a polynomial
//   active_mask() : mask of the L state bits in use for a polynomial
// ---------------------------------------------------------------------------
package prbs_pkg;

    localparam int MAX_LEN = 31;

    localparam int PRBS7_LEN  = 7;
    localparam int PRBS7_TAP  = 6;
    localparam int PRBS9_LEN  = 9;
    localparam int PRBS9_TAP  = 5;
    localparam int PRBS15_LEN = 15;
    localparam int PRBS15_TAP = 14;
    localparam int PRBS23_LEN = 23;
    localparam int PRBS23_TAP = 18;
    localparam int PRBS31_LEN = 31;
    localparam int PRBS31_TAP = 28;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_e;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } prbs_fsm_e;

    // Codes 5..7 are reserved and fall back to PRBS7.
    function automatic prbs_mode_e decode_mode(input logic [2:0] raw);
        prbs_mode_e m;
        case (raw)
            3'd1:    m = PRBS9;
            3'd2:    m = PRBS15;
            3'd3:    m = PRBS23;
            3'd4:    m = PRBS31;
            default: m = PRBS7;
        endcase
        return m;
    endfunction

    function automatic logic [MAX_LEN-1:0] active_mask(input prbs_mode_e m);
        logic [MAX_LEN-1:0] msk;
        case (m)
            PRBS9:   msk = 31'h0000_01FF;
            PRBS15:  msk = 31'h0000_7FFF;
            PRBS23:  msk = 31'h007F_FFFF;
            PRBS31:  msk = 31'h7FFF_FFFF;
            default: msk = 31'h0000_007F;
        endcase
        return msk;
    endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// ---------------------------------------------------------------------------
// prbs_lfsr_step
// Combinational DATA_WIDTH-step advance of a Fibonacci LFSR whose polynomial
// is chosen at runtime. The state holds the last L bits of the sequence with
// state[L-1] the oldest; the word emitted starts with those L bits, so a
// freshly seeded state produces the seed itself as the first bits out.
//
// Ports:
//   mode       in   active polynomial
//   state      in   current LFSR state (only the low L bits are meaningful)
//   next_state out  state after DATA_WIDTH steps (bits above L are zero)
//   word       out  DATA_WIDTH sequence bits, MSB = earliest in time
// ---------------------------------------------------------------------------
module prbs_lfsr_step
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  prbs_mode_e              mode,
    input  logic [MAX_LEN-1:0]      state,
    output logic [MAX_LEN-1:0]      next_state,
    output logic [DATA_WIDTH-1:0]   word
);

    localparam int STREAM_LEN = DATA_WIDTH + MAX_LEN;

    // Unrolls the recurrence into a flat time-ordered stream s[0..]:
    // s[0..len-1] is the current state (oldest first), every later bit
    // follows b[n] = b[n-len] ^ b[n-tap]. The word is the first DATA_WIDTH
    // stream bits and the new state is the len bits that follow them.
    // Called only with constant len/tap, so each call folds to pure XOR trees.
    function automatic logic [MAX_LEN+DATA_WIDTH-1:0] advance(
        input logic [MAX_LEN-1:0] st,
        input int                 len,
        input int                 tap
    );
        logic [STREAM_LEN-1:0] s;
        logic [MAX_LEN-1:0]    ns;
        logic [DATA_WIDTH-1:0] w;
        s  = '0;
        ns = '0;
        w  = '0;
        for (int k = 0; k < STREAM_LEN; k++) begin
            if (k < len) begin
                s[k] = st[len-1-k];
            end else if (k < DATA_WIDTH + len) begin
                s[k] = s[k-len] ^ s[k-tap];
            end
        end
        for (int k = 0; k < DATA_WIDTH; k++) begin
            w[DATA_WIDTH-1-k] = s[k];
        end
        for (int j = 0; j < MAX_LEN; j++) begin
            if (j < len) begin
                ns[len-1-j] = s[DATA_WIDTH+j];
            end
        end
        return {ns, w};
    endfunction

    logic [MAX_LEN+DATA_WIDTH-1:0] step;

    // One unrolled advance per polynomial; the mode only steers the mux.
    always_comb begin
        step = '0;
        case (mode)
            PRBS9:   step = advance(state, PRBS9_LEN,  PRBS9_TAP);
            PRBS15:  step = advance(state, PRBS15_LEN, PRBS15_TAP);
            PRBS23:  step = advance(state, PRBS23_LEN, PRBS23_TAP);
            PRBS31:  step = advance(state, PRBS31_LEN, PRBS31_TAP);
            default: step = advance(state, PRBS7_LEN,  PRBS7_TAP);
        endcase
    end

    assign next_state = step[MAX_LEN+DATA_WIDTH-1:DATA_WIDTH];
    assign word       = step[DATA_WIDTH-1:0];

endmodule

// File: rtl/prbs_gen_par.sv
// ---------------------------------------------------------------------------
// prbs_gen_par
// Parallel multi-polynomial PRBS word generator for serializer / DMRO test
// pattern paths. Each enabled cycle emits DATA_WIDTH new sequence bits.
// A SEED cycle (re)loads the LFSR after reset, after a seed_load request,
// after a mode change and after an all-zero lockup is detected.
//
// Optional build macro:
//   PRBS_ERR_INJ_EN  when defined, err_inj requests invert bit 0 of the next
//                    valid word (requests collapse, LFSR state untouched);
//                    when undefined, err_inj is ignored.
//
// Ports:
//   CLK         in   clock
//   RSTn        in   asynchronous active-low reset
//   en          in   advance the generator by DATA_WIDTH bits this cycle
//   mode[2:0]   in   0=PRBS7 1=PRBS9 2=PRBS15 3=PRBS23 4=PRBS31 5..7=PRBS7
//   seed_load   in   pulse: reseed from seed
//   seed[30:0]  in   seed value, low L bits used
//   err_inj     in   single-bit error injection request
//   data_out    out  PRBS word, MSB = earliest bit in time
//   data_valid  out  data_out holds a new word this cycle
//   lockup      out  one-cycle pulse: all-zero state detected and recovered
// ---------------------------------------------------------------------------
module prbs_gen_par
    import prbs_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [30:0] SEED_DEFAULT = 31'h7FFF_FFFF,
    parameter logic [2:0]  MODE_DEFAULT = 3'd0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  en,
    input  logic [2:0]            mode,
    input  logic                  seed_load,
    input  logic [30:0]           seed,
    input  logic                  err_inj,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  lockup
);

    prbs_fsm_e             fsm_q;
    prbs_fsm_e             fsm_d;
    logic [MAX_LEN-1:0]    lfsr_state;
    logic [MAX_LEN-1:0]    state_d;
    logic [2:0]            mode_q;
    logic [2:0]            mode_d;
    logic                  seed_pend;
    logic                  pend_d;
    logic [MAX_LEN-1:0]    seed_buf;
    logic [MAX_LEN-1:0]    buf_d;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  valid_d;
    logic                  lock_d;

    prbs_mode_e            act_mode;
    logic [MAX_LEN-1:0]    act_mask;
    logic [MAX_LEN-1:0]    load_src;
    logic [MAX_LEN-1:0]    load_masked;
    logic [MAX_LEN-1:0]    load_val;
    logic                  state_zero;
    logic [MAX_LEN-1:0]    step_state;
    logic [DATA_WIDTH-1:0] step_word;
    logic                  inj_bit;

    // The registered mode is the one the LFSR runs; reserved codes decode
    // to PRBS7 but keep their raw value so a 5->6 change still reseeds.
    assign act_mode = decode_mode(mode_q);
    assign act_mask = active_mask(act_mode);

    // A pending seed_load seed wins over the default. An all-zero seed would
    // lock the LFSR, so it is replaced by all ones in the active bits.
    assign load_src    = seed_pend ? seed_buf : SEED_DEFAULT;
    assign load_masked = load_src & act_mask;
    assign load_val    = (load_masked == '0) ? act_mask : load_masked;

    assign state_zero = ((lfsr_state & act_mask) == '0);

    prbs_lfsr_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .mode       (act_mode),
        .state      (lfsr_state),
        .next_state (step_state),
        .word       (step_word)
    );

`ifdef PRBS_ERR_INJ_EN
    logic err_pend;

    // Requests made in RUN are held until the next valid word consumes them;
    // any number of requests before that word turn into a single inversion.
    assign inj_bit = err_pend | err_inj;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            err_pend <= 1'b0;
        end else if (valid_d) begin
            err_pend <= 1'b0;
        end else if (fsm_q == ST_RUN && err_inj) begin
            err_pend <= 1'b1;
        end
    end
`else
    logic err_inj_unused;

    // Port kept for a stable interface; the output is always the pure sequence.
    assign err_inj_unused = err_inj;
    assign inj_bit        = 1'b0;
`endif

    // Next-state and register-input logic. RUN exits are prioritised:
    // seed_load, then mode change, then all-zero lockup, then normal advance.
    // The state register only moves when a word is actually produced, so the
    // first word after any SEED starts exactly at the loaded bits.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = lfsr_state;
        mode_d  = mode_q;
        pend_d  = seed_pend;
        buf_d   = seed_buf;
        dout_d  = data_out;
        valid_d = 1'b0;
        lock_d  = 1'b0;

        case (fsm_q)
            ST_SEED: begin
                state_d = load_val;
                pend_d  = 1'b0;
                fsm_d   = ST_RUN;
                // A seed arriving now is consumed by one extra SEED cycle.
                if (seed_load) begin
                    pend_d = 1'b1;
                    buf_d  = seed;
                    fsm_d  = ST_SEED;
                end
            end

            ST_RUN: begin
                if (seed_load) begin
                    pend_d = 1'b1;
                    buf_d  = seed;
                    fsm_d  = ST_SEED;
                end else if (mode != mode_q) begin
                    mode_d = mode;
                    pend_d = 1'b0;
                    fsm_d  = ST_SEED;
                end else if (state_zero) begin
                    pend_d = 1'b0;
                    lock_d = 1'b1;
                    fsm_d  = ST_SEED;
                end else if (en) begin
                    state_d = step_state;
                    dout_d  = step_word ^ {{(DATA_WIDTH-1){1'b0}}, inj_bit};
                    valid_d = 1'b1;
                end
            end

            default: begin
                fsm_d = ST_SEED;
            end
        endcase
    end

    // State register. Reset clears the outputs immediately, so a word that
    // was being produced is never flagged valid.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fsm_q      <= ST_SEED;
            lfsr_state <= SEED_DEFAULT;
            mode_q     <= MODE_DEFAULT;
            seed_pend  <= 1'b0;
            seed_buf   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            lockup     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            lfsr_state <= state_d;
            mode_q     <= mode_d;
            seed_pend  <= pend_d;
            seed_buf   <= buf_d;
            data_out   <= dout_d;
            data_valid <= valid_d;
            lockup     <= lock_d;
        end
    end

endmodule

// File: tb/tb_prbs_gen_par.sv
// ---------------------------------------------------------------------------
// tb_prbs_gen_par
// Self-checking bench for prbs_gen_par (DATA_WIDTH = 32). A bit-queue model
// of the PRBS sequence predicts every output each cycle; directed vectors
// pin known words (PRBS7 / PRBS15 / PRBS31 start words, seeded words).
// Honours PRBS_ERR_INJ_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_prbs_gen_par;

    localparam int          DW       = 32;
    localparam logic [30:0] SEED_DEF = 31'h7FFF_FFFF;

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b1;
    logic          en        = 1'b0;
    logic [2:0]    mode      = 3'd0;
    logic          seed_load = 1'b0;
    logic [30:0]   seed      = '0;
    logic          err_inj   = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          lockup;

    int n_checks = 0;
    int n_fail   = 0;

    prbs_gen_par #(
        .DATA_WIDTH   (DW),
        .SEED_DEFAULT (SEED_DEF),
        .MODE_DEFAULT (3'd0)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .err_inj    (err_inj),
        .data_out   (data_out),
        .data_valid (data_valid),
        .lockup     (lockup)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: the sequence as a growing bit list. Reseeding puts
    // the seed bits at the head; words are read DW bits at a time from a
    // read pointer and the list is extended with b[n]=b[n-L]^b[n-T].
    // ------------------------------------------------------------------
    bit            seq[$];
    int            rd;
    int            m_len;
    int            m_tap;
    logic          m_seeding;
    logic          m_pend;
    logic          m_err;
    logic [30:0]   m_seed_val;
    logic [2:0]    m_mode_q;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_lock;

    task automatic poly_of(input logic [2:0] m, output int l, output int t);
        case (m)
            3'd1:    begin l = 9;  t = 5;  end
            3'd2:    begin l = 15; t = 14; end
            3'd3:    begin l = 23; t = 18; end
            3'd4:    begin l = 31; t = 28; end
            default: begin l = 7;  t = 6;  end
        endcase
    endtask

    task automatic model_reseed(input logic [30:0] src);
        int          l;
        int          t;
        logic [63:0] msk;
        logic [30:0] v;
        poly_of(m_mode_q, l, t);
        m_len = l;
        m_tap = t;
        msk   = (64'd1 << l) - 64'd1;
        v     = src & msk[30:0];
        if (v == '0) v = msk[30:0];
        seq.delete();
        rd = 0;
        for (int i = l - 1; i >= 0; i--) seq.push_back(v[i]);
    endtask

    task automatic model_extend(input int upto);
        while (seq.size() < upto)
            seq.push_back(seq[seq.size() - m_len] ^ seq[seq.size() - m_tap]);
    endtask

    task automatic model_window_zero(output bit z);
        model_extend(rd + m_len);
        z = 1'b1;
        for (int i = 0; i < m_len; i++) if (seq[rd + i]) z = 1'b0;
    endtask

    task automatic model_next_word(output logic [DW-1:0] w);
        model_extend(rd + DW);
        for (int k = 0; k < DW; k++) w[DW-1-k] = seq[rd + k];
        rd = rd + DW;
    endtask

    always @(posedge CLK or negedge RSTn) begin
        logic [DW-1:0] w;
        bit            z;
        if (!RSTn) begin
            m_seeding = 1'b1;
            m_pend    = 1'b0;
            m_err     = 1'b0;
            m_mode_q  = 3'd0;
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_lock  = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_lock  = 1'b0;
            if (m_seeding) begin
                model_reseed(m_pend ? m_seed_val : SEED_DEF);
                m_pend    = seed_load;
                m_seeding = seed_load;
                if (seed_load) m_seed_val = seed;
            end else begin
`ifdef PRBS_ERR_INJ_EN
                if (err_inj) m_err = 1'b1;
`endif
                model_window_zero(z);
                if (seed_load) begin
                    m_pend     = 1'b1;
                    m_seed_val = seed;
                    m_seeding  = 1'b1;
                end else if (mode != m_mode_q) begin
                    m_mode_q  = mode;
                    m_seeding = 1'b1;
                end else if (z) begin
                    m_seeding = 1'b1;
                    exp_lock  = 1'b1;
                end else if (en) begin
                    model_next_word(w);
                    if (m_err) w[0] = ~w[0];
                    m_err     = 1'b0;
                    exp_data  = w;
                    exp_valid = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Every cycle: outputs must equal the model's prediction.
    always @(negedge CLK) begin
        check_output("model_valid",  {63'd0, data_valid}, {63'd0, exp_valid});
        check_output("model_lockup", {63'd0, lockup},     {63'd0, exp_lock});
        check_output("model_data",   {32'd0, data_out},   {32'd0, exp_data});
    end

    task automatic wait_valid(input string name, input int budget);
        int c;
        c = 0;
        @(negedge CLK);
        while (!data_valid && c < budget) begin
            @(negedge CLK);
            c++;
        end
        if (!data_valid) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: timeout, data_valid %0b required 1", name, data_valid);
        end
    endtask

    task automatic apply_stimulus(input logic sl, input logic [30:0] sd,
                                  input logic [2:0] md, input logic e);
        seed_load = sl;
        seed      = sd;
        mode      = md;
        en        = e;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [4:0]    en_pat;
        logic [DW-1:0] inj_exp;

        #1 RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        check_output("reset_data",   {32'd0, data_out}, 64'd0);
        check_output("reset_valid",  {63'd0, data_valid}, 64'd0);
        check_output("reset_lockup", {63'd0, lockup}, 64'd0);

        // PRBS7 from the default seed, then one full period later
        RSTn = 1'b1;
        apply_stimulus(1'b0, 31'd0, 3'd0, 1'b1);
        wait_valid("first_word", 5);
        check_output("prbs7_first", {32'd0, data_out}, 64'hFE041851);
        repeat (127) @(negedge CLK);
        check_output("prbs7_period", {32'd0, data_out}, 64'hFE041851);

        // data_valid follows en one cycle later
        en_pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            en = en_pat[i];
            @(negedge CLK);
            check_output("en_track", {63'd0, data_valid}, {63'd0, en_pat[i]});
        end

        // zero seed becomes all ones
        apply_stimulus(1'b1, 31'd0, 3'd0, 1'b1);
        @(negedge CLK);
        seed_load = 1'b0;
        wait_valid("seed0", 6);
        check_output("seed_zero", {32'd0, data_out}, 64'hFE041851);

        // seed 0000001
        apply_stimulus(1'b1, 31'h01, 3'd0, 1'b1);
        @(negedge CLK);
        seed_load = 1'b0;
        wait_valid("seed1", 6);
        check_output("seed_one", {32'd0, data_out}, 64'h020C28F2);
        repeat (3) @(negedge CLK);

        // seed_load while in SEED: the later seed wins
        apply_stimulus(1'b1, 31'h01, 3'd0, 1'b1);
        @(negedge CLK);
        seed = 31'h7F;
        @(negedge CLK);
        seed_load = 1'b0;
        wait_valid("seed_twice", 6);
        check_output("seed_in_seed", {32'd0, data_out}, 64'hFE041851);
        repeat (2) @(negedge CLK);

        // all-zero lockup and recovery
        force dut.lfsr_state = '0;
        seq.delete();
        rd = 0;
        for (int i = 0; i < m_len; i++) seq.push_back(1'b0);
        @(posedge CLK);
        #1 release dut.lfsr_state;
        @(negedge CLK);
        check_output("lockup_pulse", {63'd0, lockup}, 64'd1);
        @(negedge CLK);
        check_output("lockup_clear", {63'd0, lockup}, 64'd0);
        wait_valid("lockup_recover", 4);
        check_output("lockup_recover", {32'd0, data_out}, 64'hFE041851);

        // PRBS31, then switch to PRBS15 mid-run
        mode = 3'd4;
        @(negedge CLK);
        check_output("mode_gap31", {63'd0, data_valid}, 64'd0);
        wait_valid("prbs31", 6);
        check_output("prbs31_first", {32'd0, data_out}, 64'hFFFFFFFE);
        repeat (20) @(negedge CLK);
        mode = 3'd2;
        @(negedge CLK);
        check_output("mode_gap15", {63'd0, data_valid}, 64'd0);
        wait_valid("prbs15", 6);
        check_output("prbs15_first", {32'd0, data_out}, 64'hFFFE0004);
        repeat (20) @(negedge CLK);

        // reserved codes run PRBS7 but still count as a change
        mode = 3'd5;
        wait_valid("reserved5", 6);
        check_output("reserved5_first", {32'd0, data_out}, 64'hFE041851);
        repeat (3) @(negedge CLK);
        mode = 3'd7;
        wait_valid("reserved7", 6);
        check_output("reserved7_first", {32'd0, data_out}, 64'hFE041851);
        repeat (3) @(negedge CLK);

        // error injection requests held across en=0, collapsed into one
        apply_stimulus(1'b0, 31'd0, 3'd0, 1'b0);
        repeat (2) @(negedge CLK);
        err_inj = 1'b1;
        repeat (2) @(negedge CLK);
        err_inj = 1'b0;
        en      = 1'b1;
        @(negedge CLK);
`ifdef PRBS_ERR_INJ_EN
        inj_exp = 32'hFE041850;
`else
        inj_exp = 32'hFE041851;
`endif
        check_output("inj_valid", {63'd0, data_valid}, 64'd1);
        check_output("inj_word", {32'd0, data_out}, {32'd0, inj_exp});
        repeat (3) @(negedge CLK);

        // asynchronous reset mid-run
        @(posedge CLK);
        #3 RSTn = 1'b0;
        #1;
        check_output("async_data",  {32'd0, data_out}, 64'd0);
        check_output("async_valid", {63'd0, data_valid}, 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        wait_valid("after_reset", 5);
        check_output("after_reset", {32'd0, data_out}, 64'hFE041851);
        repeat (4) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
